// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the SEQ memory stage.
// Accepts one read/write request at a time, inserts LATENCY wait states,
// and returns read data (or a write acknowledge) over a valid/ready response.
// Misaligned or out-of-range addresses complete with dmem_error=1 and no write.
//
// Build option: define DMEM_PIPE_EN to accept a new request on the same edge
// a response is consumed (one access per LATENCY+1 cycles). Without it a
// request is only taken in IDLE (one access per LATENCY+2 cycles).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake
//   req_write               1 = write, 0 = read
//   req_addr, req_wdata     byte address and write data (64-bit)
//   resp_valid / resp_ready response handshake
//   resp_rdata              read data; 0 for writes and errored accesses
//   dmem_error              error flag of the current response
module dmem_responder #(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        dmem_error
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter only has to hold LATENCY-1.
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [60:0]   DEPTH_W  = 61'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            cap_write;
  logic [63:0]     cap_addr;
  logic [63:0]     cap_wdata;
  logic [63:0]     mem [DEPTH];

  logic            accept;
  logic            do_access;
  logic            acc_write;
  logic [63:0]     acc_addr;
  logic [63:0]     acc_wdata;
  logic [60:0]     acc_idx;
  logic            acc_err;

  assign accept = req_valid && req_ready;

  // With zero wait states the access uses the request inputs directly on the
  // accepting edge; otherwise it uses the captured copy at the end of WAIT.
  assign do_access = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == '0));
  assign acc_write = accept ? req_write : cap_write;
  assign acc_addr  = accept ? req_addr  : cap_addr;
  assign acc_wdata = accept ? req_wdata : cap_wdata;
  assign acc_idx   = acc_addr[63:3];
  assign acc_err   = (acc_addr[2:0] != 3'd0) || (acc_idx >= DEPTH_W);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
`ifdef DMEM_PIPE_EN
        req_ready  = resp_ready;
`endif
      end
      default: ;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      dmem_error <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        if (LATENCY != 0) cnt <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      // A fresh access wins over clearing the consumed response.
      if (do_access) begin
        dmem_error <= acc_err;
        resp_rdata <= (acc_err || acc_write) ? 64'd0 : mem[acc_idx[AW-1:0]];
      end else if ((state == RESP) && resp_ready) begin
        dmem_error <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage array, not reset; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && acc_write && !acc_err)
      mem[acc_idx[AW-1:0]] <= acc_wdata;
  end

endmodule
